router_ingress_arbiter: RTL and testbench
=========================================

Name: router_ingress_arbiter

Overview:
- Shares the single-input 4-way router between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered output slot drives the router's din_en/addr/din and holds while the selected destination backpressures.
- Sits directly upstream of the router; router outputs go to four sinks, each with a ready back to this block.

Parameters:
- DATA_SIZE, 32, width of data payload (matches router din).
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of grant_id (derived, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_addr  input  2*NUM_REQ  destination for requester i in bits [2i+1:2i].
- req_data  input  DATA_SIZE*NUM_REQ  payload for requester i in slice i.
- req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] and req_ready[i].
- dst_ready  input  4  sink ready per router output 0..3.
- din_en  output  1  slot valid, to router din_en.
- addr  output  2  slot destination, to router addr.
- din  output  DATA_SIZE  slot payload, to router din.
- grant_id  output  ID_W  requester index that loaded the current slot.

Behaviour:
- Reset (async assert, sync-released use): din_en=0, addr=0, din=0, grant_id=0, RR pointer=0; req_ready=0 while resetn low.
- Slot drain: drain = din_en & dst_ready[addr]. Sink consumes the router output in every cycle where drain=1.
- Slot free: free = ~din_en | drain. Grants are issued only when free=1, so back-to-back beats are sustained at full throughput.
- Arbitration (combinational):
  - Search req_valid starting at the RR pointer, ascending, with wrap.
  - First hit i gets req_ready[i]=1; all other bits are 0. At most one bit is ever set.
  - req_ready may depend combinationally on req_valid and dst_ready. No requester may make its valid depend on ready.
- Load: on a grant to i, next cycle din_en=1, addr=req_addr[i], din=req_data[i], grant_id=i, and the RR pointer becomes (i+1) mod NUM_REQ.
- Latency: 1 cycle from the accepted handshake to din_en=1.
- Hold: while din_en=1 and dst_ready[addr]=0, addr/din/grant_id stay stable, all req_ready=0, and the pointer is unchanged. Head-of-line blocking is intended; no bypass to other destinations.
- Idle: drain with no new grant gives din_en=0 and din=0 next cycle. addr and grant_id hold their last values.
- Pointer: advances only on a grant. With no valid requests it holds.
- dst_ready for non-selected destinations is ignored.
- Simultaneous drain and grant in the same cycle: the new beat replaces the old one with no bubble.
- Single requester continuously valid with dst ready: granted every cycle.
- All valid: strict rotation 0,1,2,3,0,...
- resetn asserted mid-hold: the slot is dropped (din_en=0 immediately) and the pointer returns to 0. No replay.
- Requester protocol (asserted in TB): once valid, req_addr/req_data stay stable until accepted.

Decomposition:
- Package router_pkg:
  - ROUTER_PORTS=4 and ROUTER_ADDR_W=2 constants.
  - Default DATA_SIZE.
  - typedef router_beat_t struct {logic [1:0] addr; logic [DATA_SIZE-1:0] data;} (parameterized via localparam default 32).
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], en, pointer.
  - Outputs: one-hot gnt and encoded gnt_idx.
  - Purely combinational.
  - The pointer register lives in the parent.
- Parent holds the output slot register and the pointer register.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with all req_valid=1 -> din_en=0, din=0, req_ready=0; first grant after release goes to requester 0.
- Rotation: NUM_REQ=4, all valid, dst_ready=4'hF, req_data[i]=32'hA0+i, addr=i -> din sequence A0,A1,A2,A3,A0 on consecutive cycles, grant_id 0,1,2,3,0, each one cycle after its req_ready.
- Backpressure: requester 2 sends addr=3 with data 32'hDEAD_BEEF, dst_ready[3]=0 for 5 cycles and dst_ready[0..2]=1 -> din_en=1 and din stable for 5 cycles, all req_ready=0; drains on the cycle dst_ready[3]=1, next grant lands with no bubble.
- Sparse: only requester 3 valid every other cycle -> req_ready[3] asserted each valid cycle, pointer wraps to 0, din returns to 0 on idle cycles.
- Reset mid-hold: slot loaded with addr=1 and dst_ready[1]=0, pulse resetn low asynchronously between edges -> din_en drops to 0 without waiting for clk; after release, requester 0 has priority over requester 1.
- Fairness: requesters 0 and 1 continuously valid, dst_ready toggling randomly -> grants strictly alternate 0,1,0,1; no requester is granted twice consecutively while the other is waiting.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and types for the router ingress path.
// The beat struct describes one slot as seen by the router input.
package router_pkg;

    localparam int ROUTER_PORTS      = 4;
    localparam int ROUTER_ADDR_W     = 2;
    localparam int DATA_SIZE_DEFAULT = 32;

    typedef struct packed {
        logic [ROUTER_ADDR_W-1:0]     addr;
        logic [DATA_SIZE_DEFAULT-1:0] data;
    } router_beat_t;

    // Round-robin successor of a granted index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req upward from pointer with wrap
// and returns the first hit as a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic [$clog2(N)-1:0] pointer,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic hit;
    int   cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        hit     = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(pointer) + k) % N;
            if (en && !hit && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = IW'(cand);
                hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_ingress_arbiter.sv
// Round-robin ingress arbiter feeding a single registered slot into the 4-way router.
// The slot holds while its destination backpressures (head-of-line blocking by design).
module router_ingress_arbiter
    import router_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT,
    parameter int NUM_REQ   = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [ROUTER_ADDR_W*NUM_REQ-1:0]   req_addr,
    input  logic [DATA_SIZE*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [ROUTER_PORTS-1:0]            dst_ready,
    output logic                               din_en,
    output logic [ROUTER_ADDR_W-1:0]           addr,
    output logic [DATA_SIZE-1:0]               din,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic                     din_en_q, din_en_d;
    logic [ROUTER_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0]     din_q, din_d;
    logic [ID_W-1:0]          gid_q, gid_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;

    logic                     drain;
    logic                     free;
    logic [NUM_REQ-1:0]       gnt;
    logic [ID_W-1:0]          gnt_idx;

    // A draining slot counts as free so a new beat can replace it without a bubble.
    assign drain = din_en_q & dst_ready[addr_q];
    assign free  = ~din_en_q | drain;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .en      (free & resetn),
        .pointer (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

    always_comb begin
        din_en_d = din_en_q;
        addr_d   = addr_q;
        din_d    = din_q;
        gid_d    = gid_q;
        ptr_d    = ptr_q;
        if (|gnt) begin
            din_en_d = 1'b1;
            addr_d   = req_addr[gnt_idx*ROUTER_ADDR_W +: ROUTER_ADDR_W];
            din_d    = req_data[gnt_idx*DATA_SIZE +: DATA_SIZE];
            gid_d    = gnt_idx;
            ptr_d    = ID_W'(rr_next(int'(gnt_idx), NUM_REQ));
        end else if (drain) begin
            // Idle slot shows zero data; addr and grant_id keep their last values.
            din_en_d = 1'b0;
            din_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            din_en_q <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            gid_q    <= '0;
            ptr_q    <= '0;
        end else begin
            din_en_q <= din_en_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            gid_q    <= gid_d;
            ptr_q    <= ptr_d;
        end
    end

    assign din_en   = din_en_q;
    assign addr     = addr_q;
    assign din      = din_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_router_ingress_arbiter.sv
// Directed and randomized bench for router_ingress_arbiter against a behavioural slot/pointer model.
module tb_router_ingress_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic             clk;
    logic             resetn;
    logic [N-1:0]     req_valid;
    logic [2*N-1:0]   req_addr;
    logic [DW*N-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic [3:0]       dst_ready;
    logic             din_en;
    logic [1:0]       addr;
    logic [DW-1:0]    din;
    logic [IW-1:0]    grant_id;

    router_ingress_arbiter #(
        .DATA_SIZE (DW),
        .NUM_REQ   (N)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dst_ready (dst_ready),
        .din_en    (din_en),
        .addr      (addr),
        .din       (din),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the slot contents and the next requester to favour.
    bit          m_v;
    logic [1:0]  m_addr;
    logic [31:0] m_data;
    int          m_gid;
    int          m_ptr;
    logic [N-1:0] last_gnt;
    logic [N-1:0] obs_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v      = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_gid    = 0;
        m_ptr    = 0;
        last_gnt = '0;
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (resetn !== 1'b1) return r;
        if (m_v && !dst_ready[m_addr]) return r;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_clock(input logic [N-1:0] g);
        if (!resetn) begin
            model_reset();
        end else if (g != '0) begin
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    m_v    = 1'b1;
                    m_addr = req_addr[2*i +: 2];
                    m_data = req_data[DW*i +: DW];
                    m_gid  = i;
                    m_ptr  = (i + 1) % N;
                end
            end
        end else if (m_v && dst_ready[m_addr]) begin
            m_v    = 1'b0;
            m_data = '0;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic [N-1:0] er;
        #1;
        er      = model_ready();
        obs_rdy = req_ready;
        chk("req_ready", req_ready, er);
        @(posedge clk);
        model_clock(er);
        last_gnt = er;
        #1;
        chk("din_en", din_en, m_v);
        chk("addr", addr, m_addr);
        chk("din", din, m_data);
        chk("grant_id", grant_id, m_gid);
        @(negedge clk);
    endtask

    task automatic gen_random();
        for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !last_gnt[i])) begin
                req_valid[i]        = 1'($urandom_range(0, 1));
                req_addr[2*i +: 2]  = 2'($urandom_range(0, 3));
                req_data[DW*i +: DW] = $urandom;
            end
        end
        dst_ready = 4'($urandom_range(0, 15));
    endtask

    int prev;
    int idx;

    initial begin
        resetn    = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        dst_ready = '0;
        model_reset();
        #1 resetn = 1'b0;

        // Reset held with every requester valid
        req_valid = '1;
        dst_ready = 4'hF;
        for (int i = 0; i < N; i++) begin
            req_addr[2*i +: 2]   = 2'(i);
            req_data[DW*i +: DW] = 32'hA0 + 32'(i);
        end
        @(negedge clk);
        repeat (3) step();
        chk("rst_din_en", din_en, 1'b0);
        chk("rst_din", din, 32'h0);
        chk("rst_ready", obs_rdy, 4'b0000);
        resetn = 1'b1;

        // Strict rotation with all requesters valid
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rot_ready", obs_rdy, 4'b0001 << (k % 4));
            chk("rot_gid", grant_id, k % 4);
            chk("rot_din", din, 32'hA0 + 32'(k % 4));
        end

        // Sparse: requester 3 alone, every other cycle
        req_valid = '0;
        step();
        for (int k = 0; k < 6; k++) begin
            req_valid = (k % 2 == 0) ? 4'b1000 : 4'b0000;
            req_addr[7:6]   = 2'($urandom_range(0, 3));
            req_data[127:96] = $urandom;
            step();
            if (k % 2 == 0) begin
                chk("sparse_ready", obs_rdy, 4'b1000);
                chk("sparse_gid", grant_id, 3);
            end else begin
                chk("sparse_idle_din", din, 32'h0);
                chk("sparse_idle_en", din_en, 1'b0);
            end
        end
        req_valid = '1;
        step();
        chk("wrap_gid", grant_id, 0);

        // Backpressure on destination 3
        req_valid       = 4'b0100;
        req_addr[5:4]   = 2'd3;
        req_data[95:64] = 32'hDEAD_BEEF;
        dst_ready       = 4'b0111;
        step();
        chk("bp_load", din, 32'hDEAD_BEEF);
        req_valid      = 4'b0001;
        req_addr[1:0]  = 2'd0;
        req_data[31:0] = 32'h0000_1234;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_din", din, 32'hDEAD_BEEF);
            chk("bp_hold_en", din_en, 1'b1);
            chk("bp_hold_ready", obs_rdy, 4'b0000);
        end
        dst_ready = 4'hF;
        step();
        chk("bp_release_ready", obs_rdy, 4'b0001);
        chk("bp_nobubble_din", din, 32'h0000_1234);
        chk("bp_nobubble_en", din_en, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            gen_random();
            step();
        end

        // Asynchronous reset while a beat is held
        req_valid = '0;
        dst_ready = 4'hF;
        step();
        req_valid      = 4'b0001;
        req_addr[1:0]  = 2'd1;
        req_data[31:0] = 32'h5555_AAAA;
        dst_ready      = 4'b1101;
        step();
        req_valid = '0;
        step();
        chk("hold_pre_rst", din_en, 1'b1);
        resetn = 1'b0;
        #2;
        model_reset();
        chk("async_din_en", din_en, 1'b0);
        chk("async_din", din, 32'h0);
        chk("async_ready", req_ready, 4'b0000);
        #1 resetn = 1'b1;
        req_valid = 4'b0011;
        dst_ready = 4'hF;
        step();
        chk("post_rst_gid", grant_id, 0);

        // Fairness between two always-valid requesters
        prev = 0;
        for (int k = 0; k < 100; k++) begin
            dst_ready = 4'($urandom_range(0, 15));
            step();
            if (obs_rdy != '0) begin
                idx = obs_rdy[1] ? 1 : 0;
                chk("fair_alt", idx, 1 - prev);
                prev = idx;
                req_addr[2*idx +: 2]     = 2'($urandom_range(0, 3));
                req_data[DW*idx +: DW]   = $urandom;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
